bus_arbiter: RTL

Two-port bus master that shares the 8-bit ce/rw/data peripheral bus (bar LEDs and similar chip-enable peripherals) between two requesters. It grants one transaction at a time, round-robin, and generates the setup/strobe/release sequence those peripherals need: data and rw stable before ce rises, with capture on the rising edge of ce. It sits between the host-side interface logic and the peripheral bus in the CPLD.

---
 rtl/bus_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Round-robin master for the 8-bit ce/rw/data peripheral bus shared by two requesters.
// Each grant runs one setup/strobe/release sequence; the read data is captured as ce falls.
module bus_arbiter #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [8:1] wdata0,
  input  logic [8:1] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [8:1] rdata,
  output logic       busy,
  output logic       bus_ce,
  output logic       bus_rw,
  inout  wire  [8:1] bus_data
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       grant;
  logic       last_grant;
  logic       rw_lat;
  logic [8:1] wdata_lat;
  logic       take;
  logic       pick;
  logic       sample_rd;
  logic       drive;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    // With both ports asking, the one not served last time wins.
    pick      = (req0 && req1) ? ~last_grant : req1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take      = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LAST;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LAST;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sample_rd = (state == STROBE) && (cnt == 4'd0) && rw_lat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      rw_lat     <= 1'b1;
      rdata      <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        grant      <= pick;
        last_grant <= pick;
        rw_lat     <= pick ? rw1 : rw0;
      end
      if (sample_rd) begin
        rdata <= bus_data;
      end
    end
  end

  // Write data is only ever observed while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (take) begin
      wdata_lat <= pick ? wdata1 : wdata0;
    end
  end

  assign busy     = (state != IDLE);
  assign bus_ce   = (state == STROBE);
  assign bus_rw   = busy ? rw_lat : 1'b1;
  assign ack0     = (state == RELEASE) && !grant;
  assign ack1     = (state == RELEASE) && grant;
  // A write keeps driving through RELEASE to give hold time after ce falls.
  assign drive    = busy && !rw_lat;
  assign bus_data = drive ? wdata_lat : 8'hzz;

endmodule
